// File: rtl/redmule_tcdm_responder.sv
// Responder end of the RedMulE wide TCDM data port: a DW-bit wide memory over
// 32-bit words with fixed response latency, injectable grant stalls and access counters.
module redmule_tcdm_responder #(
    parameter int          DW        = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          MEM_BYTES = 65536,
    parameter int          LATENCY   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic            wen_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [31:0]     add_i,
    input  logic [DW-1:0]   data_i,
    input  logic            user_i,
    input  logic            stall_i,
    output logic            r_valid_o,
    output logic [DW-1:0]   r_data_o,
    output logic            r_opc_o,
    output logic            r_user_o,
    output logic [31:0]     n_reads_o,
    output logic [31:0]     n_writes_o
);

    localparam int LANES     = DW / 32;
    localparam int MEM_WORDS = MEM_BYTES / 4;
    localparam int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   mem [MEM_WORDS];

    logic          accept;
    logic          addr_err;
    logic [31:0]   off;
    logic [AW-1:0] w0;
    logic [AW-1:0] lane_idx [LANES];
    logic [DW-1:0] rd_line;

    logic          pipe_valid [LATENCY];
    logic [DW-1:0] pipe_data  [LATENCY];
    logic          pipe_opc   [LATENCY];
    logic          pipe_user  [LATENCY];

    // Handshake: a transaction transfers on a rising edge where req_i & gnt_o.
    // Responses have no ready: the requester must take r_valid_o whenever it is high.
    assign gnt_o  = req_i & ~stall_i & ~rst_i;
    assign accept = req_i & gnt_o;

    assign off      = add_i - BASE_ADDR;
    assign addr_err = (add_i < BASE_ADDR) || (off >= 32'(MEM_BYTES));
    assign w0       = off[AW+1:2];

    // Word index wraps naturally because the memory depth is a power of two.
    always_comb begin
        rd_line = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i]          = w0 + AW'(i);
            rd_line[32*i +: 32]  = mem[lane_idx[i]];
        end
    end

    // Storage is intentionally outside reset so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept && !wen_i && !addr_err) begin
            for (int i = 0; i < LANES; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[4*i+b]) begin
                        mem[lane_idx[i]][8*b +: 8] <= data_i[32*i+8*b +: 8];
                    end
                end
            end
        end
    end

    // Non-valid stages carry zeros, so the outputs need no extra gating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_data[s]  <= '0;
                pipe_opc[s]   <= 1'b0;
                pipe_user[s]  <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_data[0]  <= (accept && wen_i && !addr_err) ? rd_line : '0;
            pipe_opc[0]   <= accept & addr_err;
            pipe_user[0]  <= accept & user_i;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_data[s]  <= pipe_data[s-1];
                pipe_opc[s]   <= pipe_opc[s-1];
                pipe_user[s]  <= pipe_user[s-1];
            end
        end
    end

    assign r_valid_o = pipe_valid[LATENCY-1];
    assign r_data_o  = pipe_data[LATENCY-1];
    assign r_opc_o   = pipe_opc[LATENCY-1];
    assign r_user_o  = pipe_user[LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_reads_o  <= '0;
            n_writes_o <= '0;
        end else if (accept) begin
            if (wen_i && n_reads_o != 32'hFFFF_FFFF) begin
                n_reads_o <= n_reads_o + 32'd1;
            end
            if (!wen_i && n_writes_o != 32'hFFFF_FFFF) begin
                n_writes_o <= n_writes_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Bench for redmule_tcdm_responder: LATENCY=1 and LATENCY=3 instances share stimulus
// and are checked against a word-array memory model with a timed expected-response queue.
module tb_redmule_tcdm_responder;

    localparam int          DW        = 512;
    localparam int          LANES     = DW / 32;
    localparam logic [31:0] BASE      = 32'h0001_0000;
    localparam int          MEM_BYTES = 65536;
    localparam int          WORDS     = MEM_BYTES / 4;

    logic            clk = 1'b0;
    logic            rst, req, wen, user, stall;
    logic [DW/8-1:0] be;
    logic [31:0]     add;
    logic [DW-1:0]   data;

    logic            gnt1, rv1, opc1, ru1;
    logic [DW-1:0]   rd1;
    logic [31:0]     nr1, nw1;
    logic            gnt3, rv3, opc3, ru3;
    logic [DW-1:0]   rd3;
    logic [31:0]     nr3, nw3;

    redmule_tcdm_responder #(.DW(DW), .BASE_ADDR(BASE), .MEM_BYTES(MEM_BYTES), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .wen_i(wen), .be_i(be),
        .add_i(add), .data_i(data), .user_i(user), .stall_i(stall), .r_valid_o(rv1),
        .r_data_o(rd1), .r_opc_o(opc1), .r_user_o(ru1), .n_reads_o(nr1), .n_writes_o(nw1)
    );

    redmule_tcdm_responder #(.DW(DW), .BASE_ADDR(BASE), .MEM_BYTES(MEM_BYTES), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .wen_i(wen), .be_i(be),
        .add_i(add), .data_i(data), .user_i(user), .stall_i(stall), .r_valid_o(rv3),
        .r_data_o(rd3), .r_opc_o(opc3), .r_user_o(ru3), .n_reads_o(nr3), .n_writes_o(nw3)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          opc;
        logic          user;
    } rsp_t;

    logic [31:0] mem_m [WORDS];
    rsp_t        exp_q1[$];
    rsp_t        exp_q3[$];
    rsp_t        r, e1, e3;
    logic [31:0] m_reads, m_writes;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          end_req = 0;
    bit          mon_done = 0;
    bit          d1, d3, m_err, exp_gnt;
    longint      m_off;
    int          m_w;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model runs on the rising edge, checks on the falling edge.
    initial begin
        cyc = 0;
        m_reads = 0;
        m_writes = 0;
        for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_q1.delete();
                exp_q3.delete();
                m_reads = 0;
                m_writes = 0;
            end else if (req && !stall) begin
                m_off  = longint'(add) - longint'(BASE);
                m_err  = (m_off < 0) || (m_off >= MEM_BYTES);
                r.data = '0;
                r.opc  = m_err;
                r.user = user;
                if (!m_err) begin
                    for (int i = 0; i < LANES; i++) begin
                        m_w = (int'(m_off / 4) + i) % WORDS;
                        if (wen) r.data[32*i +: 32] = mem_m[m_w];
                        else
                            for (int b = 0; b < 4; b++)
                                if (be[4*i+b]) mem_m[m_w][8*b +: 8] = data[32*i+8*b +: 8];
                    end
                end
                if (wen && m_reads != 32'hFFFF_FFFF) m_reads++;
                if (!wen && m_writes != 32'hFFFF_FFFF) m_writes++;
                r.due = cyc;
                exp_q1.push_back(r);
                r.due = cyc + 2;
                exp_q3.push_back(r);
            end

            @(negedge clk);
            exp_gnt = req && !stall && !rst;
            check($sformatf("c%0d gnt1", cyc), gnt1, exp_gnt);
            check($sformatf("c%0d gnt3", cyc), gnt3, exp_gnt);

            d1 = (exp_q1.size() > 0) && (exp_q1[0].due == cyc);
            e1 = '{0, '0, 1'b0, 1'b0};
            if (d1) e1 = exp_q1.pop_front();
            check($sformatf("c%0d rvalid1", cyc), rv1, d1);
            check($sformatf("c%0d rdata1", cyc), rd1, e1.data);
            check($sformatf("c%0d ropc1", cyc), opc1, e1.opc);
            if (d1) check($sformatf("c%0d ruser1", cyc), ru1, e1.user);

            d3 = (exp_q3.size() > 0) && (exp_q3[0].due == cyc);
            e3 = '{0, '0, 1'b0, 1'b0};
            if (d3) e3 = exp_q3.pop_front();
            check($sformatf("c%0d rvalid3", cyc), rv3, d3);
            check($sformatf("c%0d rdata3", cyc), rd3, e3.data);
            check($sformatf("c%0d ropc3", cyc), opc3, e3.opc);
            if (d3) check($sformatf("c%0d ruser3", cyc), ru3, e3.user);

            check($sformatf("c%0d nreads1", cyc), nr1, m_reads);
            check($sformatf("c%0d nwrites1", cyc), nw1, m_writes);
            check($sformatf("c%0d nreads3", cyc), nr3, m_reads);
            check($sformatf("c%0d nwrites3", cyc), nw3, m_writes);

            if (end_req && !mon_done) begin
                check("drain_q1", exp_q1.size(), 0);
                check("drain_q3", exp_q3.size(), 0);
                mon_done = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r_, input bit w_, input logic [DW/8-1:0] b_,
                         input logic [31:0] a_, input logic [DW-1:0] d_, input bit u_, input bit s_);
        req = r_; wen = w_; be = b_; add = a_; data = d_; user = u_; stall = s_;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, 32'h0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a_, input logic [DW-1:0] d_, input logic [DW/8-1:0] b_);
        drive(1'b1, 1'b0, b_, a_, d_, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a_, input bit u_);
        drive(1'b1, 1'b1, '0, a_, '0, u_, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)  return BASE + $urandom_range(0, 32'h3C3);
        if (k == 7) return BASE + MEM_BYTES - 4 * $urandom_range(1, 16) + $urandom_range(0, 3);
        if (k == 8) return BASE - $urandom_range(1, 256);
        return BASE + MEM_BYTES + $urandom_range(0, 4096);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0]   line;
        logic [DW/8-1:0] rbe;

        rst = 1'b1; req = 1'b0; wen = 1'b1; be = '0; add = '0; data = '0; user = 1'b0; stall = 1'b0;
        // Requests during reset must not be granted.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, '0, BASE, '0, 1'b1, 1'b0);
        rst = 1'b0;
        idle(1);

        // Initialise the region the bench reads: 16 lines at base and the top line.
        for (int l = 0; l < 16; l++) wr(BASE + 32'(l * 64), rand_line(), '1);
        wr(BASE + MEM_BYTES - 64, rand_line(), '1);

        // Full write then read back.
        for (int i = 0; i < LANES; i++) line[32*i +: 32] = 32'hA000_0000 + i;
        wr(BASE + 32'h100, line, '1);
        rd(BASE + 32'h100, 1'b1);
        idle(2);

        // Partial write over a zeroed line.
        wr(BASE + 32'h140, '0, '1);
        wr(BASE + 32'h140, '1, 64'h0000_0000_0000_000F);
        rd(BASE + 32'h140, 1'b0);
        idle(2);

        // Line that wraps past the last word.
        rd(BASE + MEM_BYTES - 8, 1'b1);
        idle(2);

        // Out-of-range write and read, then dump the initialised region.
        wr(BASE - 4, rand_line(), '1);
        rd(BASE + MEM_BYTES, 1'b0);
        for (int l = 0; l < 16; l++) rd(BASE + 32'(l * 64), 1'b0);
        rd(BASE + MEM_BYTES - 64, 1'b0);
        idle(3);

        // Stalled request, then back-to-back reads with alternating user bit.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, '0, BASE, '0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) rd(BASE + 32'(i * 64), i[0]);
        idle(4);

        // Reset while two reads are in flight in the deep pipeline.
        rd(BASE + 32'h100, 1'b0);
        rd(BASE + 32'h140, 1'b1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        rd(BASE + 32'h100, 1'b1);
        rd(BASE + 32'h140, 1'b0);
        idle(4);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rbe = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rbe = '0;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rbe, rand_addr(),
                  rand_line(), $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        idle(6);

        end_req = 1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
